// File: rtl/oled_spi_rx_pkg.sv
// rtl/oled_spi_rx_pkg.sv - shared opcodes, argument counts and decoder states
package oled_spi_rx_pkg;

   // Command decoder states
   typedef enum logic [1:0] {
      S_OP   = 2'd0,
      S_ARG0 = 2'd1,
      S_ARG1 = 2'd2
   } state_t;

   // Argument-count encodings as reported on cmd_nargs
   localparam logic [1:0] NARGS_0 = 2'd0;
   localparam logic [1:0] NARGS_1 = 2'd1;
   localparam logic [1:0] NARGS_2 = 2'd2;

   // Panel opcodes the decoder knows about
   localparam logic [7:0] OP_SET_CONTRAST = 8'h81;
   localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
   localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
   localparam logic [7:0] OP_COM_PINS     = 8'hDA;
   localparam logic [7:0] OP_ADDR_MODE    = 8'h20;
   localparam logic [7:0] OP_CLK_DIV      = 8'hD5;
   localparam logic [7:0] OP_MUX_RATIO    = 8'hA8;
   localparam logic [7:0] OP_DISP_OFFSET  = 8'hD3;
   localparam logic [7:0] OP_COL_ADDR     = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR    = 8'h22;
   localparam logic [7:0] OP_DISP_ON      = 8'hAF;
   localparam logic [7:0] OP_DISP_OFF     = 8'hAE;

   localparam logic [7:0] CONTRAST_RESET  = 8'h7F;

   // Number of argument bytes that follow a given opcode
   function automatic logic [1:0] nargs_of(input logic [7:0] op);
      case (op)
         OP_SET_CONTRAST, OP_CHARGE_PUMP, OP_PRECHARGE, OP_COM_PINS,
         OP_ADDR_MODE, OP_CLK_DIV, OP_MUX_RATIO, OP_DISP_OFFSET:
            nargs_of = NARGS_1;
         OP_COL_ADDR, OP_PAGE_ADDR:
            nargs_of = NARGS_2;
         default:
            nargs_of = NARGS_0;
      endcase
   endfunction

endpackage

// File: rtl/spi_rx_shift.sv
// rtl/spi_rx_shift.sv - input synchronizers, sclk/cs edge detect and byte assembly
module spi_rx_shift (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       sclk,
   input  logic       sdo,
   input  logic       dc,
   input  logic       res,
   input  logic       vdd,
   input  logic       vbat,
   output logic       soft_rst,
   output logic       vdd_s,
   output logic       vbat_s,
   output logic       byte_done,
   output logic [7:0] done_data,
   output logic       done_dc,
   output logic       frame_abort,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc
);

   // Idle levels for {cs, sclk, sdo, dc, res, vdd, vbat}: deselected, sclk high, panel out of reset
   localparam logic [6:0] SYNC_IDLE = 7'b1100100;

   logic [6:0] sync_meta;
   logic [6:0] sync_out;
   logic       cs_s, sclk_s, sdo_s, dc_s, res_s;
   logic       cs_q, sclk_q;
   logic       sclk_rise, cs_rise, cs_fall;
   logic [2:0] bit_cnt;
   logic [6:0] shreg;

   assign cs_s   = sync_out[6];
   assign sclk_s = sync_out[5];
   assign sdo_s  = sync_out[4];
   assign dc_s   = sync_out[3];
   assign res_s  = sync_out[2];
   assign vdd_s  = sync_out[1];
   assign vbat_s = sync_out[0];

   assign soft_rst  = ~res_s;
   assign sclk_rise = sclk_s & ~sclk_q;
   assign cs_rise   = cs_s & ~cs_q;
   assign cs_fall   = ~cs_s & cs_q;

   // The eighth rising edge of a byte completes it; the top decodes on this same strobe
   assign byte_done   = ~soft_rst & ~cs_s & ~cs_fall & sclk_rise & (bit_cnt == 3'd7);
   assign done_data   = {shreg, sdo_s};
   assign done_dc     = dc_s;
   assign frame_abort = ~soft_rst & cs_rise & (bit_cnt != 3'd0);

   // Two-flop synchronizers for every asynchronous panel-side input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= SYNC_IDLE;
         sync_out  <= SYNC_IDLE;
      end else begin
         sync_meta <= {cs, sclk, sdo, dc, res, vdd, vbat};
         sync_out  <= sync_meta;
      end
   end

   // Shift in sdo MSB first on sclk rising edges and publish each completed byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q       <= 1'b1;
         sclk_q     <= 1'b1;
         bit_cnt    <= 3'd0;
         shreg      <= 7'd0;
         byte_valid <= 1'b0;
         byte_data  <= 8'd0;
         byte_dc    <= 1'b0;
      end else begin
         cs_q       <= cs_s;
         sclk_q     <= sclk_s;
         byte_valid <= 1'b0;
         if (soft_rst) begin
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            byte_data <= 8'd0;
            byte_dc   <= 1'b0;
         end else if (cs_s || cs_fall) begin
            bit_cnt <= 3'd0;
         end else if (sclk_rise) begin
            shreg   <= {shreg[5:0], sdo_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
               byte_valid <= 1'b1;
               byte_data  <= done_data;
               byte_dc    <= done_dc;
            end
         end
      end
   end

endmodule

// File: rtl/oled_spi_rx.sv
// rtl/oled_spi_rx.sv - OLED SPI receiver with command decoder and panel status tracking
module oled_spi_rx
   import oled_spi_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        sclk,
   input  logic        sdo,
   input  logic        dc,
   input  logic        res,
   input  logic        vdd,
   input  logic        vbat,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_dc,
   output logic        cmd_valid,
   output logic [7:0]  cmd_op,
   output logic [7:0]  cmd_arg0,
   output logic [7:0]  cmd_arg1,
   output logic [1:0]  cmd_nargs,
   output logic        disp_on,
   output logic        charge_pump,
   output logic [7:0]  contrast,
   output logic [15:0] data_count,
   output logic        frame_err,
   output logic        seq_err,
   output logic        pwr_err
);

   logic       soft_rst, vdd_s, vbat_s;
   logic       byte_done, done_dc, frame_abort;
   logic [7:0] done_data;

   state_t     state;
   logic [7:0] pend_op, pend_arg0;

   logic       fin;
   logic [7:0] fin_op, fin_arg0, fin_arg1;
   logic [1:0] fin_nargs;

   spi_rx_shift u_shift (
      .clk         (clk),
      .rst         (rst),
      .cs          (cs),
      .sclk        (sclk),
      .sdo         (sdo),
      .dc          (dc),
      .res         (res),
      .vdd         (vdd),
      .vbat        (vbat),
      .soft_rst    (soft_rst),
      .vdd_s       (vdd_s),
      .vbat_s      (vbat_s),
      .byte_done   (byte_done),
      .done_data   (done_data),
      .done_dc     (done_dc),
      .frame_abort (frame_abort),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_dc     (byte_dc)
   );

   // Work out whether the byte completing now finishes a command, and with which fields
   always_comb begin
      fin       = 1'b0;
      fin_op    = done_data;
      fin_arg0  = 8'd0;
      fin_arg1  = 8'd0;
      fin_nargs = NARGS_0;
      if (byte_done && !done_dc) begin
         case (state)
            S_OP: begin
               fin = (nargs_of(done_data) == NARGS_0);
            end
            S_ARG0: begin
               if (nargs_of(pend_op) == NARGS_1) begin
                  fin       = 1'b1;
                  fin_op    = pend_op;
                  fin_arg0  = done_data;
                  fin_nargs = NARGS_1;
               end
            end
            S_ARG1: begin
               fin       = 1'b1;
               fin_op    = pend_op;
               fin_arg0  = pend_arg0;
               fin_arg1  = done_data;
               fin_nargs = NARGS_2;
            end
            default: fin = 1'b0;
         endcase
      end
   end

   // Decoder FSM plus the command, status and sticky error registers it drives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_OP;
         pend_op     <= 8'd0;
         pend_arg0   <= 8'd0;
         cmd_valid   <= 1'b0;
         cmd_op      <= 8'd0;
         cmd_arg0    <= 8'd0;
         cmd_arg1    <= 8'd0;
         cmd_nargs   <= NARGS_0;
         disp_on     <= 1'b0;
         charge_pump <= 1'b0;
         contrast    <= CONTRAST_RESET;
         data_count  <= 16'd0;
         frame_err   <= 1'b0;
         seq_err     <= 1'b0;
         pwr_err     <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         if (frame_abort) frame_err <= 1'b1;
         if (soft_rst) begin
            // Panel reset: drop any pending command but keep error history and data count
            state       <= S_OP;
            pend_op     <= 8'd0;
            pend_arg0   <= 8'd0;
            cmd_op      <= 8'd0;
            cmd_arg0    <= 8'd0;
            cmd_arg1    <= 8'd0;
            cmd_nargs   <= NARGS_0;
            disp_on     <= 1'b0;
            charge_pump <= 1'b0;
            contrast    <= CONTRAST_RESET;
         end else if (byte_done) begin
            if (vdd_s) pwr_err <= 1'b1;
            if (done_dc) begin
               // Display data; arriving mid-command means the command was cut short
               if (data_count != 16'hFFFF) data_count <= data_count + 16'd1;
               if (state != S_OP) seq_err <= 1'b1;
               state <= S_OP;
            end else begin
               case (state)
                  S_OP: begin
                     pend_op <= done_data;
                     if (nargs_of(done_data) != NARGS_0) state <= S_ARG0;
                  end
                  S_ARG0: begin
                     pend_arg0 <= done_data;
                     state     <= (nargs_of(pend_op) == NARGS_1) ? S_OP : S_ARG1;
                  end
                  default: state <= S_OP;
               endcase
            end
            if (fin) begin
               cmd_valid <= 1'b1;
               cmd_op    <= fin_op;
               cmd_arg0  <= fin_arg0;
               cmd_arg1  <= fin_arg1;
               cmd_nargs <= fin_nargs;
               case (fin_op)
                  OP_DISP_ON: begin
                     disp_on <= 1'b1;
                     if (vbat_s || !charge_pump) pwr_err <= 1'b1;
                  end
                  OP_DISP_OFF:     disp_on     <= 1'b0;
                  OP_SET_CONTRAST: contrast    <= fin_arg0;
                  OP_CHARGE_PUMP:  charge_pump <= fin_arg0[2];
                  default:         ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_oled_spi_rx.sv
// tb/tb_oled_spi_rx.sv - randomized self-checking bench for oled_spi_rx
module tb_oled_spi_rx;

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [1:0] n;
   } cmd_t;

   logic        clk, rst, cs, sclk, sdo, dc, res, vdd, vbat;
   logic        byte_valid, byte_dc, cmd_valid;
   logic [7:0]  byte_data, cmd_op, cmd_arg0, cmd_arg1, contrast;
   logic [1:0]  cmd_nargs;
   logic        disp_on, charge_pump, frame_err, seq_err, pwr_err;
   logic [15:0] data_count;

   int checks = 0;
   int errors = 0;

   // Observed streams (written only by the monitor)
   cmd_t       got_c[$];
   logic [8:0] got_b[$];
   int         cmd_skew = 0;

   // Reference model (written only by the stimulus process)
   cmd_t       exp_c[$];
   logic [8:0] exp_b[$];
   logic [7:0] mq[$];
   logic       m_disp, m_cp, m_frame, m_seq, m_pwr;
   logic [7:0] m_contrast;
   int         m_cnt;

   logic [7:0] op_tab [14] = '{8'h81, 8'h8D, 8'hD9, 8'hDA, 8'h20, 8'hD5, 8'hA8,
                               8'hD3, 8'h21, 8'h22, 8'hAF, 8'hAE, 8'hA5, 8'hE3};

   oled_spi_rx dut (
      .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .sdo(sdo), .dc(dc),
      .res(res), .vdd(vdd), .vbat(vbat),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg0(cmd_arg0),
      .cmd_arg1(cmd_arg1), .cmd_nargs(cmd_nargs),
      .disp_on(disp_on), .charge_pump(charge_pump), .contrast(contrast),
      .data_count(data_count), .frame_err(frame_err), .seq_err(seq_err),
      .pwr_err(pwr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_valid) got_c.push_back({cmd_op, cmd_arg0, cmd_arg1, cmd_nargs});
      if (byte_valid) got_b.push_back({byte_data, byte_dc});
      if (cmd_valid && !byte_valid) cmd_skew++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
   endtask

   function automatic int spec_nargs(input logic [7:0] op);
      if (op inside {8'h81, 8'h8D, 8'hD9, 8'hDA, 8'h20, 8'hD5, 8'hA8, 8'hD3}) return 1;
      if (op inside {8'h21, 8'h22}) return 2;
      return 0;
   endfunction

   task automatic model_init();
      mq.delete();
      m_disp = 0; m_cp = 0; m_contrast = 8'h7F;
      m_cnt = 0; m_frame = 0; m_seq = 0; m_pwr = 0;
   endtask

   task automatic model_panel_reset();
      mq.delete();
      m_disp = 0; m_cp = 0; m_contrast = 8'h7F;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic d);
      cmd_t c;
      exp_b.push_back({b, d});
      if (vdd) m_pwr = 1;
      if (d) begin
         if (mq.size() > 0) m_seq = 1;
         mq.delete();
         if (m_cnt < 65535) m_cnt++;
      end else begin
         mq.push_back(b);
         if (mq.size() == 1 + spec_nargs(mq[0])) begin
            c.op = mq[0];
            c.n  = 2'(mq.size() - 1);
            c.a0 = (mq.size() > 1) ? mq[1] : 8'd0;
            c.a1 = (mq.size() > 2) ? mq[2] : 8'd0;
            exp_c.push_back(c);
            if (c.op == 8'hAF) begin
               if (vbat || !m_cp) m_pwr = 1;
               m_disp = 1;
            end else if (c.op == 8'hAE) m_disp = 0;
            else if (c.op == 8'h81) m_contrast = c.a0;
            else if (c.op == 8'h8D) m_cp = c.a0[2];
            mq.delete();
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wclk(3);
      rst = 1'b0;
      model_init();
      wclk(3);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      wclk(4);
   endtask

   task automatic cs_high();
      wclk(4);
      cs = 1'b1;
      wclk(6);
   endtask

   task automatic send_bits(input logic [7:0] b, input logic d, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         sclk = 1'b0; sdo = b[i]; dc = d;
         wclk(4);
         sclk = 1'b1;
         wclk(4);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic d);
      send_bits(b, d, 8);
      model_byte(b, d);
   endtask

   task automatic pulse_res();
      res = 1'b0;
      wclk(5);
      res = 1'b1;
      wclk(5);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({byte_valid, byte_data, byte_dc, cmd_valid, cmd_op, cmd_arg0, cmd_arg1, cmd_nargs,
           disp_on, charge_pump, data_count, frame_err, seq_err, pwr_err} !== '0) begin
         errors++;
         $display("FAIL reset_zero: outputs not all zero (data_count=%h cmd_op=%h disp_on=%b)",
                  data_count, cmd_op, disp_on);
      end
      checks++;
      if (contrast !== 8'h7F) begin
         errors++; $display("FAIL reset_contrast: got %h expected 7f", contrast);
      end
   endtask

   task automatic test_disp_off();
      int base = got_c.size();
      int skew0 = cmd_skew;
      cs_low(); send_byte(8'hAE, 1'b0); cs_high();
      checks++;
      if (got_c.size() != base + 1) begin
         errors++; $display("FAIL disp_off_count: got %0d cmds expected 1", got_c.size() - base);
      end else begin
         checks++;
         if (got_c[base].op !== 8'hAE || got_c[base].n !== 2'd0) begin
            errors++; $display("FAIL disp_off_cmd: got op=%h n=%0d expected op=ae n=0",
                               got_c[base].op, got_c[base].n);
         end
      end
      checks++;
      if (cmd_skew != skew0) begin
         errors++; $display("FAIL disp_off_same_clk: cmd_valid without byte_valid %0d times", cmd_skew - skew0);
      end
      checks++;
      if ({disp_on, frame_err, seq_err, pwr_err} !== 4'b0) begin
         errors++; $display("FAIL disp_off_status: got disp/frame/seq/pwr=%b expected 0000",
                            {disp_on, frame_err, seq_err, pwr_err});
      end
   endtask

   task automatic test_charge_pump();
      int base = got_c.size();
      cs_low(); send_byte(8'h8D, 1'b0); send_byte(8'h14, 1'b0); cs_high();
      checks++;
      if (got_c.size() != base + 1) begin
         errors++; $display("FAIL cp_count: got %0d cmds expected 1", got_c.size() - base);
      end else begin
         checks++;
         if (got_c[base].op !== 8'h8D || got_c[base].a0 !== 8'h14 || got_c[base].n !== 2'd1) begin
            errors++; $display("FAIL cp_cmd: got op=%h a0=%h n=%0d expected 8d 14 1",
                               got_c[base].op, got_c[base].a0, got_c[base].n);
         end
      end
      checks++;
      if (charge_pump !== 1'b1) begin
         errors++; $display("FAIL cp_flag: got %b expected 1", charge_pump);
      end
   endtask

   task automatic test_seq_err();
      int base = got_c.size();
      cs_low(); send_byte(8'h81, 1'b0); send_byte(8'h10, 1'b1); cs_high();
      checks++;
      if (got_c.size() != base) begin
         errors++; $display("FAIL seq_no_cmd: got %0d cmds expected 0", got_c.size() - base);
      end
      checks++;
      if (seq_err !== 1'b1 || data_count !== 16'd1 || contrast !== 8'h7F) begin
         errors++; $display("FAIL seq_status: got seq=%b count=%0d contrast=%h expected 1 1 7f",
                            seq_err, data_count, contrast);
      end
   endtask

   task automatic test_frame_err();
      int base = got_c.size();
      int bbase = got_b.size();
      cs_low(); send_bits(8'hA5, 1'b0, 5); cs_high();
      m_frame = 1;
      checks++;
      if (frame_err !== 1'b1 || got_b.size() != bbase) begin
         errors++; $display("FAIL frame_abort: got frame_err=%b bytes=%0d expected 1 0",
                            frame_err, got_b.size() - bbase);
      end
      vbat = 1'b0;
      cs_low(); send_byte(8'hAF, 1'b0); cs_high();
      checks++;
      if (got_c.size() != base + 1 || got_c[got_c.size() - 1].op !== 8'hAF) begin
         errors++; $display("FAIL frame_next_cmd: got %0d cmds expected one af", got_c.size() - base);
      end
      checks++;
      if (disp_on !== 1'b1 || pwr_err !== 1'b0 || frame_err !== 1'b1) begin
         errors++; $display("FAIL frame_status: got disp=%b pwr=%b frame=%b expected 1 0 1",
                            disp_on, pwr_err, frame_err);
      end
   endtask

   task automatic test_panel_reset();
      int base = got_c.size();
      cs_low();
      send_byte(8'h21, 1'b0);
      pulse_res();
      model_panel_reset();
      checks++;
      if (got_c.size() != base) begin
         errors++; $display("FAIL res_no_cmd: got %0d cmds expected 0", got_c.size() - base);
      end
      checks++;
      if (contrast !== 8'h7F || disp_on !== 1'b0 || charge_pump !== 1'b0) begin
         errors++; $display("FAIL res_status: got contrast=%h disp=%b cp=%b expected 7f 0 0",
                            contrast, disp_on, charge_pump);
      end
      checks++;
      if (frame_err !== 1'b1 || seq_err !== 1'b1 || data_count !== 16'd1) begin
         errors++; $display("FAIL res_retain: got frame=%b seq=%b count=%0d expected 1 1 1",
                            frame_err, seq_err, data_count);
      end
      send_byte(8'hE3, 1'b0);
      cs_high();
      checks++;
      if (got_c.size() != base + 1 || got_c[got_c.size() - 1].op !== 8'hE3
          || got_c[got_c.size() - 1].n !== 2'd0) begin
         errors++; $display("FAIL res_back_to_op: got %0d cmds expected one e3 with n=0", got_c.size() - base);
      end
   endtask

   task automatic test_pwr_and_rst();
      vdd = 1'b1;
      cs_low(); send_byte(8'hA5, 1'b0); cs_high();
      vdd = 1'b0;
      checks++;
      if (pwr_err !== 1'b1) begin
         errors++; $display("FAIL pwr_vdd: got %b expected 1", pwr_err);
      end
      do_reset();
      @(negedge clk);
      checks++;
      if ({frame_err, seq_err, pwr_err} !== 3'b000) begin
         errors++; $display("FAIL pwr_rst_clear: got frame/seq/pwr=%b expected 000",
                            {frame_err, seq_err, pwr_err});
      end
   endtask

   task automatic test_back_to_back();
      int cbase, bbase, skew0, nbad;
      logic [7:0] b;
      logic d;
      do_reset();
      cbase = got_c.size();
      bbase = got_b.size();
      skew0 = cmd_skew;
      exp_c.delete();
      exp_b.delete();
      cs_low();
      for (int n = 0; n < 70; n++) begin
         int r = $urandom_range(0, 99);
         if (r < 4) begin
            send_bits(8'($urandom), 1'b0, $urandom_range(1, 7));
            cs_high();
            m_frame = 1;
            cs_low();
         end else if (r < 7) begin
            pulse_res();
            model_panel_reset();
         end else if (r < 13) begin
            cs_high();
            cs_low();
         end else begin
            vdd  = ($urandom_range(0, 15) == 0);
            vbat = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0);
            if (!d && $urandom_range(0, 4) != 0) b = op_tab[$urandom_range(0, 13)];
            else b = 8'($urandom);
            send_byte(b, d);
            vdd = 1'b0;
         end
      end
      cs_high();
      checks++;
      if (got_b.size() - bbase != exp_b.size()) begin
         errors++; $display("FAIL b2b_byte_count: got %0d expected %0d", got_b.size() - bbase, exp_b.size());
      end else begin
         nbad = 0;
         foreach (exp_b[i]) if (got_b[bbase + i] !== exp_b[i]) nbad++;
         checks++;
         if (nbad != 0) begin
            errors++; $display("FAIL b2b_byte_data: %0d bytes differ from model", nbad);
         end
      end
      checks++;
      if (got_c.size() - cbase != exp_c.size()) begin
         errors++; $display("FAIL b2b_cmd_count: got %0d expected %0d", got_c.size() - cbase, exp_c.size());
      end else begin
         foreach (exp_c[i]) begin
            checks++;
            if (got_c[cbase + i] !== exp_c[i]) begin
               errors++; $display("FAIL b2b_cmd[%0d]: got %h expected %h", i, got_c[cbase + i], exp_c[i]);
            end
         end
      end
      checks++;
      if (cmd_skew != skew0) begin
         errors++; $display("FAIL b2b_same_clk: cmd_valid without byte_valid %0d times", cmd_skew - skew0);
      end
      checks++;
      if ({disp_on, charge_pump, contrast} !== {m_disp, m_cp, m_contrast}) begin
         errors++; $display("FAIL b2b_status: got disp=%b cp=%b contrast=%h expected %b %b %h",
                            disp_on, charge_pump, contrast, m_disp, m_cp, m_contrast);
      end
      checks++;
      if (data_count !== m_cnt[15:0]) begin
         errors++; $display("FAIL b2b_data_count: got %0d expected %0d", data_count, m_cnt);
      end
      checks++;
      if ({frame_err, seq_err, pwr_err} !== {m_frame, m_seq, m_pwr}) begin
         errors++; $display("FAIL b2b_errors: got frame/seq/pwr=%b expected %b",
                            {frame_err, seq_err, pwr_err}, {m_frame, m_seq, m_pwr});
      end
   endtask

   initial begin
      cs = 1'b1; sclk = 1'b1; sdo = 1'b0; dc = 1'b0;
      res = 1'b1; vdd = 1'b0; vbat = 1'b0;
      do_reset();
      test_reset();
      test_disp_off();
      test_charge_pump();
      test_seq_err();
      test_frame_err();
      test_panel_reset();
      test_pwr_and_rst();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/oled_spi_rx.md
OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-002 SHALL have ports: clk input 1 system clock; rst input 1 async reset.
REQ-003 SHALL have ports cs, sclk, sdo, dc as inputs, 1 bit each: SPI chip select (active-low), serial clock, serial data, data/command select (0 = command).
REQ-004 SHALL have ports res, vdd, vbat as inputs, 1 bit each: panel reset (active-low) and logic/panel supply enables (active-low, 0 = on).
REQ-005 SHALL have ports byte_valid output 1, byte_data output 8 and byte_dc output 1: a one-clk pulse, then the received byte and its dc level.
REQ-006 SHALL have ports cmd_valid output 1, cmd_op output 8, cmd_arg0 output 8, cmd_arg1 output 8 and cmd_nargs output 2: a one-clk pulse when a command is complete, then its opcode, arguments and argument count.
REQ-007 SHALL have status outputs: disp_on 1, charge_pump 1, contrast 8, data_count 16.
REQ-008 SHALL have sticky error outputs frame_err 1, seq_err 1 and pwr_err 1.

Function
REQ-009 SHALL pass cs, sclk, sdo, dc, res, vdd and vbat through 2-flop synchronizers; clk SHALL be at least 4x sclk.
REQ-010 SHALL sample sdo on the synchronized sclk rising edge while cs=0, MSB first, with sclk idling high (mode 3).
REQ-011 SHALL clear the 3-bit bit counter on cs falling and on cs high.
REQ-012 SHALL pulse byte_valid in the clk after the 8th sampled edge is detected; byte_data and byte_dc (dc sampled with bit 0) SHALL hold until the next byte.
REQ-013 SHALL accept back-to-back bytes without cs deassertion; the counter SHALL wrap 7->0.
REQ-014 SHALL set frame_err and discard the partial byte when cs rises with the counter nonzero.
REQ-015 SHALL implement the decoder FSM states S_OP, S_ARG0 and S_ARG1.
REQ-016 In S_OP, a dc=0 byte SHALL be the opcode. Opcodes 0x81, 0x8D, 0xD9, 0xDA, 0x20, 0xD5, 0xA8 and 0xD3 SHALL take 1 argument; 0x21 and 0x22 SHALL take 2; all others SHALL take 0.
REQ-017 A 0-argument opcode SHALL pulse cmd_valid in the same clk as byte_valid, with cmd_nargs=0.
REQ-018 Otherwise the FSM SHALL go to S_ARG0. From there, the next dc=0 byte SHALL go to arg0, then either complete the command or go to S_ARG1, and the next byte SHALL go to arg1 and complete it.
REQ-019 A dc=1 byte received in S_ARG0 or S_ARG1 SHALL set seq_err, drop the pending command (no cmd_valid), count the byte as data and return to S_OP.
REQ-020 A dc=1 byte in S_OP SHALL increment data_count, which saturates at 0xFFFF.
REQ-021 On command completion: 0xAF SHALL set disp_on and 0xAE SHALL clear it; 0x81 SHALL load contrast from arg0; 0x8D SHALL load charge_pump from arg0 bit 2.
REQ-022 Any byte received while vdd=1 SHALL set pwr_err. Completing 0xAF while vbat=1 or charge_pump=0 SHALL also set pwr_err; disp_on SHALL still be set.
REQ-023 A frame error mid-argument SHALL leave the FSM state unchanged.
REQ-024 Status and error outputs SHALL update one clk after cmd_valid, or in the same clk as cmd_valid where registered together; the bench SHALL check them one clk after cmd_valid.

Reset
REQ-025 On rst, all outputs SHALL be 0, except contrast=0x7F, and the FSM SHALL be in S_OP with the bit counter at 0.
REQ-026 Synchronized res=0 SHALL synchronously apply the REQ-025 state, except that the error flags and data_count SHALL be retained; an in-flight byte or command SHALL be discarded without any error.
REQ-027 Error flags SHALL clear only on rst.

Structure
REQ-028 Opcode constants, argument-count values and FSM state encodings SHALL live in a shared package/include alongside the existing state definitions.
REQ-029 The design SHALL use one sub-module, spi_rx_shift: the synchronizers, edge detection and byte assembly. Decoding SHALL stay in the top level.

Verification
REQ-030 With vdd=0, send 0xAE (dc=0) -> one cmd_valid, cmd_op=0xAE, cmd_nargs=0, disp_on=0, no errors.
REQ-031 Send 0x8D then 0x14 in one cs frame -> exactly one cmd_valid, cmd_op=0x8D, cmd_arg0=0x14, charge_pump=1.
REQ-032 Send 0x81 then 0x10 with dc=1 -> no cmd_valid, seq_err=1, data_count=1, contrast=0x7F.
REQ-033 Raise cs after 5 bits, then send 0xAF with vbat=0 and charge_pump=1 -> frame_err=1, then cmd_op=0xAF, disp_on=1, pwr_err=0.
REQ-034 Pulse res=0 between 0x21 and its first argument -> no cmd_valid, FSM in S_OP, contrast=0x7F, disp_on=0.
REQ-035 Send 0xA5 with vdd=1 -> pwr_err=1; then rst -> all flags 0.
